// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point ALU blocks.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
    input  logic [23:0] v,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) cnt = 5'(23 - i);
        end
    end
endmodule

// File: rtl/f_sub.sv
// Binary32 subtractor OUT_SUB = A - B: combinational add path on A + (-B),
// flush-to-zero on input and output, round-to-nearest-even, one output register.
module f_sub
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        RST,
    input  logic        EN,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] OUT_SUB
);
    // No handshake: operands present at a rising edge with EN=1 are accepted
    // that edge and their difference is on OUT_SUB right after it; EN=0 holds.
    fp32_t a, bn;
    assign a  = A;
    assign bn = {~B[31], B[30:0]};

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (a.exp == 8'h00);
    assign b_zero = (bn.exp == 8'h00);
    assign a_inf  = (a.exp == 8'hFF) && (a.frac == '0);
    assign b_inf  = (bn.exp == 8'hFF) && (bn.frac == '0);
    assign a_nan  = (a.exp == 8'hFF) && (a.frac != '0);
    assign b_nan  = (bn.exp == 8'hFF) && (bn.frac != '0);

    logic [23:0] ma, mb, ml, ms;
    logic [7:0]  el, es, d;
    logic        sl, a_ge, eff_add;
    assign ma      = {1'b1, a.frac};
    assign mb      = {1'b1, bn.frac};
    assign a_ge    = {a.exp, ma} >= {bn.exp, mb};
    assign sl      = a_ge ? a.sign : bn.sign;
    assign el      = a_ge ? a.exp : bn.exp;
    assign es      = a_ge ? bn.exp : a.exp;
    assign ml      = a_ge ? ma : mb;
    assign ms      = a_ge ? mb : ma;
    assign d       = el - es;
    assign eff_add = (a.sign == bn.sign);

    // Aligned smaller operand as {significand, guard, round, sticky}.
    logic [49:0] wide;
    logic [26:0] sm;
    logic [27:0] sum;
    assign wide = {ms, 26'b0} >> d;
    assign sm   = (d >= 8'd26) ? 27'd1 : {wide[49:24], |wide[23:0]};
    assign sum  = eff_add ? ({1'b0, ml, 3'b0} + {1'b0, sm})
                          : ({1'b0, ml, 3'b0} - {1'b0, sm});

    logic [4:0] lz;
    fp_lzc24 u_lzc (
        .v   (sum[26:3]),
        .cnt (lz)
    );

    logic [26:0]       nm;
    logic signed [9:0] ne, fe;
    logic              rnd_up;
    logic [24:0]       mr;
    logic [22:0]       fm;

    always_comb begin
        nm = '0;
        ne = '0;
        if (sum[27]) begin
            nm = {sum[27:4], sum[3], sum[2], sum[1] | sum[0]};
            ne = $signed({2'b00, el}) + 10'sd1;
        end else begin
            nm = sum[26:0] << lz;
            ne = $signed({2'b00, el}) - $signed({5'b00000, lz});
        end
        rnd_up = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr     = {1'b0, nm[26:3]} + {24'b0, rnd_up};
        if (mr[24]) begin
            fm = mr[23:1];
            fe = ne + 10'sd1;
        end else begin
            fm = mr[22:0];
            fe = ne;
        end
    end

    logic [31:0] res;
    always_comb begin
        res = '0;
        if (a_nan || b_nan)           res = QNAN;
        else if (a_inf && b_inf)      res = (a.sign == bn.sign) ? a : QNAN;
        else if (a_inf)               res = a;
        else if (b_inf)               res = bn;
        else if (a_zero && b_zero)    res = {a.sign & bn.sign, 31'b0};
        else if (b_zero)              res = a;
        else if (a_zero)              res = bn;
        else if (sum == '0)           res = '0;
        else if (fe >= $signed(10'(EXP_MAX))) res = {sl, 8'hFF, 23'b0};
        else if (fe <= 10'sd0)        res = {sl, 31'b0};
        else                          res = {sl, fe[7:0], fm};
    end

    always_ff @(posedge clk) begin
        if (RST)     OUT_SUB <= '0;
        else if (EN) OUT_SUB <= res;
    end
endmodule

// File: tb/tb_f_sub.sv
// Randomised scoreboard bench for f_sub against a real-arithmetic reference.
module tb_f_sub;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] B   = '0;
    logic [31:0] OUT_SUB;

    f_sub dut (
        .clk     (clk),
        .RST     (RST),
        .EN      (EN),
        .A       (A),
        .B       (B),
        .OUT_SUB (OUT_SUB)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_exp = '0;
    bit          done = 1'b0;

    function automatic real to_real(input logic [31:0] x);
        logic [63:0] db;
        db = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'b0};
        return $bitstoreal(db);
    endfunction

    // Exact difference in double, then one RNE rounding to 24 bits.
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bn;
        logic        a_z, b_z;
        real         r;
        logic [63:0] db;
        int          de, be;
        logic [52:0] m53;
        logic [24:0] keep;
        logic [28:0] rem;
        bn  = b ^ 32'h8000_0000;
        a_z = (a[30:23] == 8'h00);
        b_z = (bn[30:23] == 8'h00);
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (bn[30:23] == 8'hFF && bn[22:0] != 0))
            return 32'h7FC0_0000;
        if (a[30:23] == 8'hFF && bn[30:23] == 8'hFF)
            return (a[31] == bn[31]) ? a : 32'h7FC0_0000;
        if (a[30:23] == 8'hFF) return a;
        if (bn[30:23] == 8'hFF) return bn;
        if (a_z && b_z) return {a[31] & bn[31], 31'b0};
        if (b_z) return a;
        if (a_z) return bn;
        r = to_real(a) - to_real(b);
        if (r == 0.0) return 32'h0000_0000;
        db   = $realtobits(r);
        de   = int'(db[62:52]) - 1023;
        m53  = {1'b1, db[51:0]};
        keep = {1'b0, m53[52:29]};
        rem  = m53[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            de++;
        end
        be = de + 127;
        if (be >= 255) return {db[63], 8'hFF, 23'b0};
        if (be <= 0) return {db[63], 31'b0};
        return {db[63], be[7:0], keep[22:0]};
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [31:0] a,
                         input logic [31:0] b, input string name);
        logic [31:0] e;
        @(negedge clk);
        RST = rst;
        EN  = en;
        A   = a;
        B   = b;
        if (rst)     e = 32'h0;
        else if (en) e = ref_sub(a, b);
        else         e = last_exp;
        last_exp = e;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    function automatic logic [31:0] rand_fp(input int exp_lo, input int exp_hi);
        return {1'($urandom_range(1, 0)), 8'($urandom_range(exp_hi, exp_lo)), 23'($urandom())};
    endfunction

    // Monitor: the register presents a result every edge; compare it against the oldest expectation.
    initial begin
        logic [31:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (OUT_SUB !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h (A=%08h B=%08h)", nm, OUT_SUB, e, A, B);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        int          mode, ex;
        drive(1'b1, 1'b0, 32'h1234_5678, 32'h0, "reset");
        drive(1'b0, 1'b1, 32'hC000_0000, 32'h3F80_0000, "basic_m2_m1");
        drive(1'b0, 1'b1, 32'hC086_6666, 32'h404C_CCCC, "diff_exp_add");
        drive(1'b0, 1'b1, 32'hBF28_F5C2, 32'h3F02_8F5C, "carry_renorm");
        drive(1'b0, 1'b1, 32'hC0CC_CCCC, 32'hBF00_0000, "neg_sub_neg");
        drive(1'b0, 1'b1, 32'h40CC_CCCC, 32'hBF00_0000, "neg_sub_pos");
        drive(1'b0, 1'b0, 32'h3F80_0000, 32'h4000_0000, "hold_en0");
        drive(1'b0, 1'b0, 32'h4100_0000, 32'h3F80_0000, "hold_en0_2");
        drive(1'b1, 1'b1, 32'h4100_0000, 32'h3F80_0000, "rst_over_en");
        drive(1'b0, 1'b1, 32'h4049_0FDB, 32'h4049_0FDB, "exact_cancel");
        drive(1'b0, 1'b1, 32'h7F80_0000, 32'h7F80_0000, "inf_minus_inf");
        drive(1'b0, 1'b1, 32'h7F7F_FFFF, 32'hFF7F_FFFF, "overflow");
        drive(1'b0, 1'b1, 32'h7FC1_2345, 32'h3F80_0000, "nan_in");
        drive(1'b0, 1'b1, 32'h3F80_0000, 32'h7F80_0000, "x_minus_inf");
        drive(1'b0, 1'b1, 32'h4040_0000, 32'h0000_0000, "x_minus_zero");
        drive(1'b0, 1'b1, 32'h0000_0000, 32'h4040_0000, "zero_minus_y");
        drive(1'b0, 1'b1, 32'h0040_0000, 32'hC0A0_0000, "denorm_minus_y");
        drive(1'b0, 1'b1, 32'h0080_0001, 32'h0080_0000, "underflow");
        drive(1'b0, 1'b1, 32'h3F80_0000, 32'h337F_FFFF, "sticky_only");

        for (int i = 0; i < 400; i++) begin
            ra   = rand_fp(1, 254);
            mode = $urandom_range(5, 0);
            if (mode <= 2) begin
                ex = int'(ra[30:23]) + $urandom_range(6, 0) - 3;
                if (ex < 1) ex = 1;
                if (ex > 254) ex = 254;
                rb = rand_fp(ex, ex);
            end else if (mode == 3) begin
                rb = {ra[31], ra[30:0] ^ {23'b0, 8'($urandom())}};
            end else if (mode == 4) begin
                rb = rand_fp(1, 254);
            end else begin
                rb = rand_fp(0, 255);
                if ($urandom_range(1, 0) == 1) ra = rand_fp(0, 255);
            end
            drive($urandom_range(49, 0) == 0, $urandom_range(9, 0) != 0, ra, rb, "random");
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, "final_hold");

        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/f_sub.md
Name: f_sub

Overview:
- Single-precision IEEE-754 floating-point subtractor computing OUT_SUB = A - B.
- Implemented as combinational unpack/align/add-sub/normalise/round logic feeding one output register.
- Sits in the floating-point ALU beside the adder, multiplier and divider, and shares their operand/result format.

Parameters:
- None. The format is fixed binary32: sign bit 31, exponent 30:23 with bias 127, fraction 22:0.

Ports:
- clk      input   1   rising-edge clock
- RST      input   1   synchronous, active-high reset
- EN       input   1   register enable; OUT_SUB loads only when EN=1
- A        input   32  minuend, binary32
- B        input   32  subtrahend, binary32
- OUT_SUB  output  32  registered difference A - B, binary32

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (clk, RST).
- Reset: on a rising edge with RST=1, OUT_SUB <= 32'h0000_0000. RST has priority over EN.
- Latency and enable:
  - Latency is 1 cycle. A and B are sampled at a rising edge with EN=1, and the result is visible after that edge.
  - With EN=0, OUT_SUB holds its value.
  - No handshake; a new operand pair can be accepted every cycle.
- Operation:
  - Compute A + (-B) by flipping B's sign bit, then run the standard add path.
  - Effective operation is an add when the signs are equal after the flip, otherwise a subtract.
- Unpack:
  - Exponent 0 denotes zero or a denormal; denormals are flushed to signed zero on input.
  - Otherwise the significand is {1, fraction}, 24 bits.
- Align:
  - Swap operands so the larger magnitude is first (compare exponent, then significand).
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - A difference of 26 or more reduces the smaller operand to sticky only.
- Add/subtract:
  - Use a 25-bit significand path plus G/R/S.
  - Result sign is the sign of the larger-magnitude operand.
- Normalise:
  - On carry-out, shift right 1 and increment the exponent.
  - On cancellation, shift left by the leading-zero count and decrement the exponent.
- Round: round-to-nearest-even on G/R/S. A rounding carry renormalises once more.
- Exact zero result (including A == B) is +0, 32'h0000_0000.
- Overflow: exponent >= 255 gives a signed infinity, exponent 8'hFF with fraction 0.
- Underflow: exponent <= 0 gives a signed zero (flush-to-zero output).
- Specials:
  - Either operand NaN gives the canonical qNaN 32'h7FC0_0000.
  - inf - inf with the same sign gives qNaN.
  - An infinity operand otherwise gives that infinity, with the sign applied after B's negation.
  - x - 0 = x.
  - 0 - y = -y.
- No exception flags are output.

Decomposition:
- Shared package fp_pkg holds:
  - field width constants EXP_W=8, FRAC_W=23 and BIAS=127;
  - the QNAN constant 32'h7FC0_0000;
  - a packed struct for the binary32 fields {sign, exp, frac}.
- One sub-module, fp_lzc24: 24-bit leading-zero counter (5-bit count) used in normalisation.
- All other logic is inline.

Test Plan:
- Basic difference: A=32'hC000_0000 (-2), B=32'h3F80_0000 (1), EN=1 -> OUT_SUB=32'hC040_0000 (-3) one edge later.
- Different exponents, effective add: A=32'hC086_6666 (-4.2), B=32'h404C_CCCC (3.2) -> 32'hC0EC_CCCC (-7.4).
- Same exponent, carry-out renormalise: A=32'hBF28_F5C2 (-0.66), B=32'h3F02_8F5C (0.51) -> 32'hBF95_C28F (-1.17).
- Negative subtrahend, both sign cases:
  - A=32'hC0CC_CCCC (-6.4), B=32'hBF00_0000 (-0.5) -> 32'hC0BC_CCCC (-5.9).
  - A=32'h40CC_CCCC (6.4), same B -> 32'h40DC_CCCC (6.9).
- Control and cancellation:
  - RST=1 for one edge -> OUT_SUB=0.
  - EN=0 with new operands -> OUT_SUB holds the previous value.
  - A=B=32'h4049_0FDB -> 32'h0000_0000.
- Specials:
  - A=32'h7F80_0000, B=32'h7F80_0000 -> 32'h7FC0_0000.
  - A=32'h7F7F_FFFF, B=32'hFF7F_FFFF -> 32'h7F80_0000 (overflow).
